// File: rtl/mult_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter_pkg
// Shared constants and width helpers for the shared-multiplier arbiter.
//   WIDTH_DEF / N_REQ_DEF : default operand width and requester count
//   id_width()            : requester index width (at least one bit)
//   s1_entry_width()      : packed S1 entry {a, b, id}
//   s2_entry_width()      : packed S2 entry {product, id}
// -----------------------------------------------------------------------------
package mult_share_arbiter_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_REQ_DEF = 4;

  // A single requester still needs a one-bit id field to keep ports legal.
  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int s1_entry_width(input int width, input int n_req);
    return (2 * width) + id_width(n_req);
  endfunction

  function automatic int s2_entry_width(input int width, input int n_req);
    return (2 * width) + id_width(n_req);
  endfunction

  localparam int IDW_DEF = id_width(N_REQ_DEF);
  localparam int S1W_DEF = s1_entry_width(WIDTH_DEF, N_REQ_DEF);
  localparam int S2W_DEF = s2_entry_width(WIDTH_DEF, N_REQ_DEF);

endpackage

// File: rtl/mult_share_arbiter_wallace.sv
// -----------------------------------------------------------------------------
// Wallace_Tree_Multiplier
// Combinational unsigned multiplier. Partial products are reduced with layers
// of 3:2 carry-save compressors until two rows remain, then summed once.
//   a_i       : multiplicand, width bits
//   b_i       : multiplier, width bits
//   product_o : unsigned a_i * b_i, 2*width bits
// -----------------------------------------------------------------------------
module Wallace_Tree_Multiplier #(
  parameter int width = 8
) (
  input  logic [width-1:0]   a_i,
  input  logic [width-1:0]   b_i,
  output logic [2*width-1:0] product_o
);

  localparam int PW = 2 * width;
  // Row storage needs room for at least two rows for the final adder.
  localparam int NR = (width < 2) ? 2 : width;

  // The row count only depends on width, so every loop and index below folds
  // to a fixed compressor network at elaboration.
  function automatic logic [PW-1:0] wallace_mul(input logic [width-1:0] a,
                                                input logic [width-1:0] b);
    logic [PW-1:0] rows [NR];
    logic [PW-1:0] nxt  [NR];
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [PW-1:0] z;
    int cnt;
    int grp;
    int rem;
    for (int i = 0; i < NR; i++) begin
      rows[i] = '0;
      nxt[i]  = '0;
    end
    for (int i = 0; i < width; i++) begin
      rows[i] = b[i] ? (PW'(a) << i) : '0;
    end
    cnt = width;
    for (int lvl = 0; lvl < NR; lvl++) begin
      if (cnt > 2) begin
        grp = cnt / 3;
        rem = cnt - (3 * grp);
        for (int j = 0; j < NR; j++) begin
          nxt[j] = '0;
        end
        for (int g = 0; g < NR / 3; g++) begin
          if (g < grp) begin
            x = rows[3*g];
            y = rows[3*g+1];
            z = rows[3*g+2];
            nxt[2*g]   = x ^ y ^ z;
            // The carry out of the top column is dropped: the true product
            // always fits in PW bits, so the modular sum stays exact.
            nxt[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
          end
        end
        for (int r = 0; r < 2; r++) begin
          if (r < rem) begin
            nxt[2*grp+r] = rows[3*grp+r];
          end
        end
        rows = nxt;
        cnt  = (2 * grp) + rem;
      end
    end
    return rows[0] + rows[1];
  endfunction

  assign product_o = wallace_mul(a_i, b_i);

endmodule

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
// N_REQ requesters share one multiplier through a round-robin arbiter and a
// two-stage pipeline (S1 = operands, S2 = result).
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-requester request
//   req_ready   : per-requester accept, at most one bit high
//   req_a/req_b : packed operands, requester i at [i*WIDTH +: WIDTH]
//   res_valid   : result available; res_ready : consumer accept
//   res_product : unsigned product; res_id : issuing requester
//   busy        : any pipeline stage occupied
//   done_count  : completed results, wrapping 16-bit counter
// -----------------------------------------------------------------------------
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IDW   = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*WIDTH-1:0]     res_product,
  output logic [IDW-1:0]         res_id,
  output logic                   busy,
  output logic [15:0]            done_count
);

  localparam int PW  = 2 * WIDTH;
  localparam int S1W = s1_entry_width(WIDTH, N_REQ);
  localparam int S2W = s2_entry_width(WIDTH, N_REQ);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);

  // S1 entry is {a, b, id}; S2 entry is {product, id}.
  logic [S1W-1:0]   s1_entry_q, s1_entry_d;
  logic             s1_valid_q, s1_valid_d;
  logic [S2W-1:0]   s2_entry_q, s2_entry_d;
  logic             res_valid_q, res_valid_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [15:0]      done_count_q, done_count_d;

  logic             s2_can_load_s;
  logic             s1_can_load_s;
  logic             req_fire_s;
  logic             res_fire_s;
  logic             grant_found_s;
  logic [IDW-1:0]   grant_s;
  logic [IDW:0]     scan_sum_s;
  logic [IDW-1:0]   scan_idx_s;
  logic [IDW:0]     ptr_inc_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0] s1_a_s;
  logic [WIDTH-1:0] s1_b_s;
  logic [IDW-1:0]   s1_id_s;
  logic [PW-1:0]    mult_p_s;

  assign s1_a_s  = s1_entry_q[S1W-1 -: WIDTH];
  assign s1_b_s  = s1_entry_q[IDW +: WIDTH];
  assign s1_id_s = s1_entry_q[IDW-1:0];

  Wallace_Tree_Multiplier #(
    .width(WIDTH)
  ) u_mult (
    .a_i      (s1_a_s),
    .b_i      (s1_b_s),
    .product_o(mult_p_s)
  );

  // Round-robin scan: first valid requester at or above ptr, modulo N_REQ.
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = '0;
    scan_sum_s    = '0;
    scan_idx_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum_s = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_sum_s >= NREQ_W) begin
        scan_sum_s = scan_sum_s - NREQ_W;
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[IDW-1:0];
      if (!grant_found_s && req_valid[scan_idx_s]) begin
        grant_found_s = 1'b1;
        grant_s       = scan_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s == IDW'(i)) begin
        sel_a_s = req_a[i*WIDTH +: WIDTH];
        sel_b_s = req_b[i*WIDTH +: WIDTH];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  // Handshakes; ready is gated by rst_n so nothing is accepted during reset.
  always_comb begin
    s2_can_load_s = !res_valid_q || res_ready;
    s1_can_load_s = !s1_valid_q || s2_can_load_s;
    req_fire_s    = grant_found_s && s1_can_load_s;
    res_fire_s    = res_valid_q && res_ready;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = rst_n && req_fire_s && (grant_s == IDW'(i));
    end
  end

  // Next-state for both stages, the arbitration pointer and the counter.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_entry_d   = s1_entry_q;
    res_valid_d  = res_valid_q;
    s2_entry_d   = s2_entry_q;
    ptr_d        = ptr_q;
    done_count_d = done_count_q;
    ptr_inc_s    = {1'b0, grant_s} + {{IDW{1'b0}}, 1'b1};

    if (s1_can_load_s) begin
      s1_valid_d = req_fire_s;
      if (req_fire_s) begin
        s1_entry_d = {sel_a_s, sel_b_s, grant_s};
      end else begin
        s1_entry_d = s1_entry_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // S2 reloads from S1 in the same edge it drains.
    if (s2_can_load_s) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_entry_d = {mult_p_s, s1_id_s};
      end else begin
        s2_entry_d = s2_entry_q;
      end
    end else begin
      res_valid_d = res_valid_q;
    end

    if (req_fire_s) begin
      ptr_d = (ptr_inc_s == NREQ_W) ? '0 : ptr_inc_s[IDW-1:0];
    end else begin
      ptr_d = ptr_q;
    end

    if (res_fire_s) begin
      done_count_d = done_count_q + 16'd1;
    end else begin
      done_count_d = done_count_q;
    end
  end

  // State registers with asynchronous clear of everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_entry_q   <= '0;
      res_valid_q  <= 1'b0;
      s2_entry_q   <= '0;
      ptr_q        <= '0;
      done_count_q <= 16'd0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_entry_q   <= s1_entry_d;
      res_valid_q  <= res_valid_d;
      s2_entry_q   <= s2_entry_d;
      ptr_q        <= ptr_d;
      done_count_q <= done_count_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_product = s2_entry_q[S2W-1 -: PW];
  assign res_id      = s2_entry_q[IDW-1:0];
  assign busy        = s1_valid_q | res_valid_q;
  assign done_count  = done_count_q;

endmodule
